// File: rtl/edge_event_monitor.sv
// Multi-channel sampled-value checker ($rose/$fell/$stable/$changed) with
// pass/fail pulses, saturating counters, sticky errors and first-failure capture.
module edge_event_monitor #(
    parameter int NCH          = 4,
    parameter int CNT_W        = 16,
    parameter int TS_W         = 32,
    parameter int STOP_ON_FAIL = 0,
    localparam int CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic [2*NCH-1:0]     mode,
    input  logic [NCH-1:0]       sig,
    output logic [NCH-1:0]       pass,
    output logic [NCH-1:0]       fail,
    output logic [NCH*CNT_W-1:0] pass_cnt,
    output logic [NCH*CNT_W-1:0] fail_cnt,
    output logic [NCH-1:0]       err_sticky,
    output logic                 first_fail_vld,
    output logic [CH_W-1:0]      first_fail_ch,
    output logic [TS_W-1:0]      first_fail_ts,
    output logic                 halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PRIME = 2'b01,
        RUN   = 2'b10,
        HALT  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state_r;
    state_t            state_nxt_s;
    logic [NCH-1:0]    prev_r;
    logic [TS_W-1:0]   cyc_r;
    logic [NCH-1:0]    ok_s;
    logic [NCH-1:0]    pass_s;
    logic [NCH-1:0]    fail_s;
    logic [CH_W-1:0]   low_idx_s;
    logic              evaluate_s;

    // Per-channel rule check of the current sample against the previous one.
    always_comb begin
        ok_s = '0;
        for (int i = 0; i < NCH; i++) begin
            case (mode[2*i +: 2])
                2'b00:   ok_s[i] = ~prev_r[i] & sig[i];
                2'b01:   ok_s[i] = prev_r[i] & ~sig[i];
                2'b10:   ok_s[i] = ~(prev_r[i] ^ sig[i]);
                2'b11:   ok_s[i] = prev_r[i] ^ sig[i];
                default: ok_s[i] = 1'b0;
            endcase
        end
    end

    // Only a RUN edge with en high is judged; every judged channel yields exactly one of pass/fail.
    always_comb begin
        evaluate_s = (state_r == RUN) && en;
        if (evaluate_s) begin
            pass_s = ok_s;
            fail_s = ~ok_s;
        end else begin
            pass_s = '0;
            fail_s = '0;
        end
    end

    // Lowest failing channel index; scanning downwards leaves the lowest one last.
    always_comb begin
        low_idx_s = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (fail_s[i]) begin
                low_idx_s = CH_W'(i);
            end else begin
                low_idx_s = low_idx_s;
            end
        end
    end

    // Next-state decode of the monitor FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (en) begin
                    state_nxt_s = PRIME;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PRIME: begin
                if (en) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nxt_s = IDLE;
                end else if ((STOP_ON_FAIL != 0) && (|fail_s)) begin
                    state_nxt_s = HALT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            HALT: begin
                if (clr) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HALT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM, history, cycle counter and result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            halted  <= 1'b0;
            prev_r  <= '0;
            cyc_r   <= '0;
            pass    <= '0;
            fail    <= '0;
        end else begin
            state_r <= state_nxt_s;
            halted  <= (state_nxt_s == HALT);
            cyc_r   <= cyc_r + TS_W'(1);
            pass    <= pass_s;
            fail    <= fail_s;
            if ((state_r == PRIME) || evaluate_s) begin
                prev_r <= sig;
            end
        end
    end

    // Statistics: saturating counters, sticky errors, first-failure capture; clr beats a same-edge fail.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            err_sticky     <= '0;
            first_fail_vld <= 1'b0;
            first_fail_ch  <= '0;
            first_fail_ts  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (pass_s[i] && (pass_cnt[i*CNT_W +: CNT_W] != CNT_MAX)) begin
                    pass_cnt[i*CNT_W +: CNT_W] <= pass_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
                if (fail_s[i] && (fail_cnt[i*CNT_W +: CNT_W] != CNT_MAX)) begin
                    fail_cnt[i*CNT_W +: CNT_W] <= fail_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
            err_sticky <= err_sticky | fail_s;
            if (!first_fail_vld && (|fail_s)) begin
                first_fail_vld <= 1'b1;
                first_fail_ch  <= low_idx_s;
                first_fail_ts  <= cyc_r;
            end
        end
    end

endmodule
